// File: rtl/goertzel_bank.sv
// rtl/goertzel_bank.sv - time-multiplexed multi-bin Goertzel filter bank on one shared multiplier
`timescale 1ns/1ps
module goertzel_bank #(
  parameter int NF = 11,
  parameter int N  = 205,
  parameter int DW = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coef_valid,
  input  logic [NF-1:0][63:0] alpha_i,
  input  logic [NF-1:0][63:0] cos_i,
  input  logic [NF-1:0][63:0] sin_i,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DW-1:0]       s_data,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [7:0]          o_bin,
  output logic [63:0]         o_re,
  output logic [63:0]         o_im,
  output logic                o_last
);

  localparam int KW = (NF > 1) ? $clog2(NF) : 1;
  localparam int CW = 12;
  localparam logic [KW-1:0] K_LAST = KW'(NF - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    WAIT_COEF = 3'd0,
    IDLE      = 3'd1,
    ITER      = 3'd2,
    FIN_RE    = 3'd3,
    FIN_IM    = 3'd4,
    OUT       = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     x_q;
  logic [63:0]     re_q;
  logic [63:0]     im_q;
  logic [63:0]     s1_q [NF];
  logic [63:0]     s2_q [NF];

  logic            accept;
  logic [63:0]     mul_a, mul_b, mul_r;
  logic [127:0]    prod;
  logic [63:0]     s_new;

  assign accept = (state_q == IDLE) && s_valid && s_ready;

  // Shared multiplier operand select: feedback term in ITER, cos/sin terms in the finishing states
  always_comb begin
    mul_a = alpha_i[k_q];
    mul_b = s1_q[k_q];
    case (state_q)
      FIN_RE: begin
        mul_a = cos_i[k_q];
        mul_b = s2_q[k_q];
      end
      FIN_IM: begin
        mul_a = sin_i[k_q];
        mul_b = s2_q[k_q];
      end
      default: ;
    endcase
  end

  // 20.44 fixed-point product: full signed 128-bit product, keep bits [107:44] (floor toward -inf)
  always_comb begin
    prod  = {{64{mul_a[63]}}, mul_a} * {{64{mul_b[63]}}, mul_b};
    mul_r = 64'(prod >> 44);
    s_new = x_q + mul_r - s2_q[k_q];
  end

  // State, bin index and sample count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_COEF;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: per-sample sweep over all bins, then one finish/output pass per bin
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_COEF: begin
        if (coef_valid) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          state_d = ITER;
          k_d     = '0;
        end else if (!coef_valid && cnt_q == '0) begin
          state_d = WAIT_COEF;
        end
      end
      ITER: begin
        if (k_q == K_LAST) begin
          k_d = '0;
          if (cnt_q == C_LAST) begin
            cnt_d   = '0;
            state_d = FIN_RE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = IDLE;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      FIN_RE: state_d = FIN_IM;
      FIN_IM: state_d = OUT;
      OUT: begin
        if (o_ready) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = IDLE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = FIN_RE;
          end
        end
      end
      default: state_d = WAIT_COEF;
    endcase
  end

  // Output decode; results are presented only while in OUT, otherwise everything reads zero
  always_comb begin
    s_ready = 1'b0;
    o_valid = 1'b0;
    o_bin   = '0;
    o_re    = '0;
    o_im    = '0;
    o_last  = 1'b0;
    case (state_q)
      // With no coefficients and no block in flight the FSM falls back to WAIT_COEF, so do not offer ready
      IDLE: s_ready = coef_valid || (cnt_q != '0);
      OUT: begin
        o_valid = 1'b1;
        o_bin   = 8'(k_q);
        o_re    = re_q;
        o_im    = im_q;
        o_last  = (k_q == K_LAST);
      end
      default: ;
    endcase
  end

  // Datapath: sample latch, Goertzel state update, finishing terms, per-bin clear on result handoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      re_q <= '0;
      im_q <= '0;
      for (int i = 0; i < NF; i++) begin
        s1_q[i] <= '0;
        s2_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) x_q <= {{(64-DW){s_data[DW-1]}}, s_data} << 44;
        end
        ITER: begin
          s1_q[k_q] <= s_new;
          s2_q[k_q] <= s1_q[k_q];
        end
        FIN_RE: re_q <= s1_q[k_q] - mul_r;
        FIN_IM: im_q <= mul_r;
        OUT: begin
          if (o_ready) begin
            s1_q[k_q] <= '0;
            s2_q[k_q] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
